// File: rtl/hilo_mult_unit_if.sv
// Execute-stage request/response bundle between the control unit and the HI/LO multiply unit.
interface hilo_mult_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             enhilo_EX;
    logic             signed_EX;
    logic [WIDTH-1:0] opa_EX;
    logic [WIDTH-1:0] opb_EX;
    logic [1:0]       regsel_EX;
    logic [WIDTH-1:0] hilo_rdata_EX;
    logic             busy;
    logic             stall_EX;
    logic             done;

    modport master (
        output enhilo_EX, signed_EX, opa_EX, opb_EX, regsel_EX,
        input  hilo_rdata_EX, busy, stall_EX, done
    );

    modport slave (
        input  enhilo_EX, signed_EX, opa_EX, opb_EX, regsel_EX,
        output hilo_rdata_EX, busy, stall_EX, done
    );
endinterface

// File: rtl/hilo_mult_unit.sv
// Shift-add multiplier (one multiplier bit per clock) with HI/LO result registers
// and mfhi/mflo read port; stalls EX while a request cannot be served.
module hilo_mult_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    hilo_mult_unit_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [PW-1:0]    prod;
    logic             busy;

    // Operand magnitudes; the most negative value maps to its unsigned magnitude.
    always_comb begin
        mag_a = (bus.signed_EX && bus.opa_EX[WIDTH-1]) ? (~bus.opa_EX + WIDTH'(1)) : bus.opa_EX;
        mag_b = (bus.signed_EX && bus.opb_EX[WIDTH-1]) ? (~bus.opb_EX + WIDTH'(1)) : bus.opb_EX;
        prod  = neg_q ? (~acc_q + PW'(1)) : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enhilo_EX) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = bus.signed_EX & (bus.opa_EX[WIDTH-1] ^ bus.opb_EX[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                if (mplier_q[cnt_q]) begin
                    acc_d = acc_q + (mcand_q << cnt_q);
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIX: begin
                hi_d    = prod[PW-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
        end
    end

    // Reads always show the committed HI/LO; they are held off while busy via stall_EX.
    assign busy     = (state_q != IDLE);
    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.stall_EX = busy & (bus.enhilo_EX | (bus.regsel_EX == 2'd1) | (bus.regsel_EX == 2'd2));
    assign bus.hilo_rdata_EX = (bus.regsel_EX == 2'd1) ? hi_q :
                               (bus.regsel_EX == 2'd2) ? lo_q : '0;
endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit: vector table with a result scoreboard,
// plus sequences for stalled reads, held starts and mid-operation reset.
module tb_hilo_mult_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_mult_unit_if #(.WIDTH(32)) bus ();
    hilo_mult_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic [31:0] last_lo = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
        return {32'h0, a} * {32'h0, b};
    endfunction

    // Leaves the bench at the falling edge after the start edge E0, request dropped.
    task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.enhilo_EX = 1'b1;
        bus.signed_EX = s;
        bus.opa_EX    = a;
        bus.opb_EX    = b;
        @(negedge clk);
        bus.enhilo_EX = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Waits for completion, pops the scoreboard and reads HI/LO back through the read port.
    task automatic finish_op(input string tag);
        int n;
        logic [63:0] exp;
        wait_idle(n);
        chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        bus.regsel_EX = 2'd1;
        #1;
        chk({tag, "_hi"}, 64'(bus.hilo_rdata_EX), 64'(exp[63:32]));
        chk({tag, "_stall"}, 64'(bus.stall_EX), 64'd0);
        bus.regsel_EX = 2'd2;
        #1;
        chk({tag, "_lo"}, 64'(bus.hilo_rdata_EX), 64'(exp[31:0]));
        bus.regsel_EX = 2'd0;
        last_lo = exp[31:0];
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int n;
        logic [31:0] ra, rb;

        rst = 1'b0;
        bus.enhilo_EX = 1'b0;
        bus.signed_EX = 1'b0;
        bus.opa_EX    = '0;
        bus.opb_EX    = '0;
        bus.regsel_EX = 2'd2;

        vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001});
        vecs.push_back('{1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB});
        vecs.push_back('{1'b0, 32'hFFFFFFFD, 32'h00000007, 64'h00000006_FFFFFFEB});
        vecs.push_back('{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000});
        vecs.push_back('{1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000});
        vecs.push_back('{1'b1, 32'h00000000, 32'h80000001, 64'h0});
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            vecs.push_back('{1'(i & 1), ra, rb, model(1'(i & 1), ra, rb)});
        end

        // Reset state
        #12;
        chk("rst_lo", 64'(bus.hilo_rdata_EX), 64'd0);
        bus.regsel_EX = 2'd1;
        #1;
        chk("rst_hi", 64'(bus.hilo_rdata_EX), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_stall", 64'(bus.stall_EX), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        bus.regsel_EX = 2'd0;
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            sb.push_back(v.exp);
            start_op(v.s, v.a, v.b);
            finish_op($sformatf("vec%0d", i));
        end

        // Read issued mid-operation stalls and shows the old LO until the FIX edge
        sb.push_back(model(1'b0, 32'd5, 32'd9));
        start_op(1'b0, 32'd5, 32'd9);
        repeat (4) @(negedge clk);
        bus.regsel_EX = 2'd2;
        n = 0;
        while (bus.busy && n < 100) begin
            #1;
            chk("rd_stall_busy", 64'(bus.stall_EX), 64'd1);
            chk("rd_old_lo", 64'(bus.hilo_rdata_EX), 64'(last_lo));
            n++;
            @(negedge clk);
        end
        chk("rd_stall_cycles", 64'(n), 64'd29);
        #1;
        chk("rd_stall_clear", 64'(bus.stall_EX), 64'd0);
        chk("rd_new_lo", 64'(bus.hilo_rdata_EX), 64'd45);
        bus.regsel_EX = 2'd0;
        last_lo = 32'd45;
        void'(sb.pop_front());

        // Start held through busy (with changing operands) is accepted only at E34
        sb.push_back(model(1'b0, 32'h0000_1234, 32'h0000_0100));
        start_op(1'b0, 32'h0000_1234, 32'h0000_0100);
        bus.enhilo_EX = 1'b1;
        bus.signed_EX = 1'b1;
        bus.opa_EX    = 32'hFFFF_FFFE;
        bus.opb_EX    = 32'h0000_0011;
        #1;
        chk("hold_stall", 64'(bus.stall_EX), 64'd1);
        wait_idle(n);
        chk("hold_busy_cycles", 64'(n), 64'd33);
        chk("hold_not_taken", 64'(bus.busy), 64'd0);
        chk("hold_done", 64'(bus.done), 64'd1);
        chk("hold_no_stall_idle", 64'(bus.stall_EX), 64'd0);
        bus.regsel_EX = 2'd2;
        #1;
        chk("hold_first_lo", 64'(bus.hilo_rdata_EX), 64'h0012_3400);
        bus.regsel_EX = 2'd0;
        void'(sb.pop_front());
        @(negedge clk);
        chk("hold_started_e34", 64'(bus.busy), 64'd1);
        bus.enhilo_EX = 1'b0;
        sb.push_back(model(1'b1, 32'hFFFF_FFFE, 32'h0000_0011));
        finish_op("hold_second");

        // Asynchronous reset in the middle of MUL abandons the operation
        start_op(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(negedge clk);
        chk("midrst_busy_before", 64'(bus.busy), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        bus.regsel_EX = 2'd1;
        #1;
        chk("midrst_hi", 64'(bus.hilo_rdata_EX), 64'd0);
        chk("midrst_stall", 64'(bus.stall_EX), 64'd0);
        bus.regsel_EX = 2'd2;
        #1;
        chk("midrst_lo", 64'(bus.hilo_rdata_EX), 64'd0);
        bus.regsel_EX = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        sb.push_back(64'd42);
        start_op(1'b1, 32'd6, 32'd7);
        finish_op("after_rst");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
